// File: rtl/fp_adder_pkg.sv
// Shared definitions for the FP32 adder host controller.
// Optional feature macro: FPH_TIMEOUT_EN (WAIT_ORDY abort counter).
package fp_adder_pkg;

    localparam int WORD_W = 32;
    localparam int SETUP_W = 8;
    localparam int CNT_W = 5;
    localparam logic [3:0] SETUP_EN_ALL = 4'b1111;
    localparam logic SETUP_CLK_INT = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IRDY,
        LOAD,
        WAIT_ORDY,
        READ,
        DONE
    } fph_state_e;

    // Setup byte sent to the adder: subtract selects, all stages enabled, internal output clock.
    function automatic logic [SETUP_W-1:0] setup_byte(input logic [2:0] sub_op);
        return {sub_op, SETUP_EN_ALL, SETUP_CLK_INT};
    endfunction

endpackage

// File: rtl/fph_piso32.sv
// 32-bit parallel-load / shift-left register presenting its MSB as a serial stream.
module fph_piso32
    import fp_adder_pkg::*;
(
    input  logic              clk_in,
    input  logic              load_in,
    input  logic              shift_in,
    input  logic [WORD_W-1:0] data_in,
    output logic              msb_out
);

    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_d;

    // Load has priority; a shift brings the next lower bit up to the MSB.
    always_comb begin
        sr_d = sr_q;
        if (load_in) begin
            sr_d = data_in;
        end else if (shift_in) begin
            sr_d = {sr_q[WORD_W-2:0], 1'b0};
        end
    end

    // Pure data storage; the host gates the stream so no reset is needed here.
    always_ff @(posedge clk_in) begin
        sr_q <= sr_d;
    end

    assign msb_out = sr_q[WORD_W-1];

endmodule

// File: rtl/fp_adder_host.sv
// Host controller for a bit-serial FP32 adder: loads four operands plus a
// setup byte serially, waits for the result and shifts it back in.
// Optional feature macro: FPH_TIMEOUT_EN (abort WAIT_ORDY after TIMEOUT_CYCLES).
module fp_adder_host
    import fp_adder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [WORD_W-1:0] op_a_in,
    input  logic [WORD_W-1:0] op_b_in,
    input  logic [WORD_W-1:0] op_c_in,
    input  logic [WORD_W-1:0] op_d_in,
    input  logic [2:0]        sub_op_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [WORD_W-1:0] result_out,
    output logic              timeout_out,
    output logic              serial1_out,
    output logic              serial2_out,
    output logic              serial3_out,
    output logic              serial4_out,
    output logic              setup_serial_out,
    output logic              wr_out,
    input  logic              dev_input_rdy_in,
    input  logic              dev_output_rdy_in,
    output logic              output_read_out,
    input  logic              dev_serial_in
);

    fph_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SETUP_W-1:0] setup_q, setup_d;
    logic [WORD_W-1:0]  sr_q, sr_d;
    logic [WORD_W-1:0]  result_q, result_d;
    logic               busy_q, wr_q, rd_q, done_q;
    logic               run_q;
    logic               start_ok;
    logic               msb_a, msb_b, msb_c, msb_d;

`ifdef FPH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // run_q releases one edge after reset deassertion, so the first start counts on the second edge.
    assign start_ok = run_q && start_in && (state_q == IDLE);

    fph_piso32 u_piso_a (.clk_in(clk_in), .load_in(start_ok), .shift_in(state_q == LOAD),
                         .data_in(op_a_in), .msb_out(msb_a));
    fph_piso32 u_piso_b (.clk_in(clk_in), .load_in(start_ok), .shift_in(state_q == LOAD),
                         .data_in(op_b_in), .msb_out(msb_b));
    fph_piso32 u_piso_c (.clk_in(clk_in), .load_in(start_ok), .shift_in(state_q == LOAD),
                         .data_in(op_c_in), .msb_out(msb_c));
    fph_piso32 u_piso_d (.clk_in(clk_in), .load_in(start_ok), .shift_in(state_q == LOAD),
                         .data_in(op_d_in), .msb_out(msb_d));

    // Next-state, bit counter, setup latch and result assembly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        setup_d  = setup_q;
        sr_d     = sr_q;
        result_d = result_q;
`ifdef FPH_TIMEOUT_EN
        timeout_d = 1'b0;
        tmo_cnt_d = (state_q == WAIT_ORDY) ? tmo_cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = WAIT_IRDY;
                    setup_d = setup_byte(sub_op_in);
                end
            end
            WAIT_IRDY: begin
                if (dev_input_rdy_in) begin
                    state_d = LOAD;
                    cnt_d   = '1;
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_ORDY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_ORDY: begin
                if (dev_output_rdy_in) begin
                    state_d = READ;
                    cnt_d   = '1;
                end
`ifdef FPH_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            READ: begin
                sr_d = {sr_q[WORD_W-2:0], dev_serial_in};
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = {sr_q[WORD_W-2:0], dev_serial_in};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, counters and registered control outputs; reset forces everything idle at once.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            setup_q   <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            done_q    <= 1'b0;
            run_q     <= 1'b0;
`ifdef FPH_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            setup_q   <= setup_d;
            result_q  <= result_d;
            busy_q    <= (state_d != IDLE);
            wr_q      <= (state_d == LOAD);
            rd_q      <= (state_d == READ);
            done_q    <= (state_d == DONE);
            run_q     <= 1'b1;
`ifdef FPH_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Result shift register is data only and is fully refilled before use.
    always_ff @(posedge clk_in) begin
        sr_q <= sr_d;
    end

    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign result_out       = result_q;
    assign wr_out           = wr_q;
    assign output_read_out  = rd_q;
    assign serial4_out      = wr_q & msb_a;
    assign serial3_out      = wr_q & msb_b;
    assign serial2_out      = wr_q & msb_c;
    assign serial1_out      = wr_q & msb_d;
    // Bit counter runs 31..0 in LOAD, so the setup byte occupies the last eight slots.
    assign setup_serial_out = wr_q & (cnt_q < CNT_W'(SETUP_W)) & setup_q[cnt_q[2:0]];
`ifdef FPH_TIMEOUT_EN
    assign timeout_out      = timeout_q;
`else
    assign timeout_out      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_adder_host.sv
// Directed testbench for fp_adder_host with a cycle-level adder stub.
module tb_fp_adder_host;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        start_in = 1'b0;
    logic [31:0] op_a_in = '0, op_b_in = '0, op_c_in = '0, op_d_in = '0;
    logic [2:0]  sub_op_in = '0;
    logic        busy_out, done_out, timeout_out;
    logic [31:0] result_out;
    logic        serial1_out, serial2_out, serial3_out, serial4_out, setup_serial_out, wr_out;
    logic        dev_input_rdy_in = 1'b0, dev_output_rdy_in = 1'b0, dev_serial_in = 1'b0;
    logic        output_read_out;

    int errors = 0;
    int checks = 0;

    int wr_first, wr_last, wr_count, read_count, done_count, done_cycle;
    int tmo_count, tmo_cycle, busy_last, idle_bad, setup_bad;
    logic [31:0] cap_a, cap_b, cap_c, cap_d, res_at_done;
    logic [7:0]  setup_seq;

    fp_adder_host #(.TIMEOUT_CYCLES(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .op_a_in(op_a_in), .op_b_in(op_b_in), .op_c_in(op_c_in), .op_d_in(op_d_in),
        .sub_op_in(sub_op_in), .busy_out(busy_out), .done_out(done_out),
        .result_out(result_out), .timeout_out(timeout_out),
        .serial1_out(serial1_out), .serial2_out(serial2_out),
        .serial3_out(serial3_out), .serial4_out(serial4_out),
        .setup_serial_out(setup_serial_out), .wr_out(wr_out),
        .dev_input_rdy_in(dev_input_rdy_in), .dev_output_rdy_in(dev_output_rdy_in),
        .output_read_out(output_read_out), .dev_serial_in(dev_serial_in)
    );

    always #5 clk_in = ~clk_in;

    // Start one operation in the current cycle (cycle 0) and observe cycles 1..ncyc.
    // Operand inputs are scrambled after the start cycle to prove they were latched.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [2:0] sub, input logic [31:0] stub,
                         input int irdy_hold, input int ordy_hold, input int ncyc);
        int rd_bit;
        op_a_in = a; op_b_in = b; op_c_in = c; op_d_in = d; sub_op_in = sub;
        start_in = 1'b1;
        dev_input_rdy_in = (irdy_hold == 0);
        dev_output_rdy_in = (ordy_hold == 0);
        dev_serial_in = 1'b0;
        wr_first = -1; wr_last = -1; wr_count = 0; read_count = 0; done_count = 0;
        done_cycle = -1; tmo_count = 0; tmo_cycle = -1; busy_last = -1;
        idle_bad = 0; setup_bad = 0; res_at_done = '0;
        cap_a = '0; cap_b = '0; cap_c = '0; cap_d = '0; setup_seq = '0;
        rd_bit = 31;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk_in); #1;
            op_a_in = ~a; op_b_in = ~b; op_c_in = ~c; op_d_in = ~d; sub_op_in = ~sub;
            start_in = (k <= irdy_hold) && (k % 3 == 1);
            dev_input_rdy_in = (k > irdy_hold);
            dev_output_rdy_in = (k > ordy_hold);
            if (busy_out) busy_last = k;
            if (wr_out) begin
                wr_count++;
                if (wr_first < 0) wr_first = k;
                wr_last = k;
                cap_a = {cap_a[30:0], serial4_out};
                cap_b = {cap_b[30:0], serial3_out};
                cap_c = {cap_c[30:0], serial2_out};
                cap_d = {cap_d[30:0], serial1_out};
                if (wr_count >= 25) setup_seq = {setup_seq[6:0], setup_serial_out};
                else if (setup_serial_out) setup_bad++;
            end else if (serial1_out | serial2_out | serial3_out | serial4_out | setup_serial_out) begin
                idle_bad++;
            end
            if (output_read_out) begin
                read_count++;
                dev_serial_in = stub[rd_bit];
                if (rd_bit > 0) rd_bit--;
            end else begin
                dev_serial_in = 1'b0;
            end
            if (done_out) begin
                done_count++;
                done_cycle = k;
                res_at_done = result_out;
            end
            if (timeout_out) begin
                tmo_count++;
                tmo_cycle = k;
            end
        end
        start_in = 1'b0;
        dev_serial_in = 1'b0;
    endtask

    task automatic release_reset();
        rst_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset();
        logic [10:0] ctl;
        rst_in = 1'b0; start_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        ctl = {busy_out, done_out, wr_out, output_read_out, timeout_out, serial1_out,
               serial2_out, serial3_out, serial4_out, setup_serial_out, 1'b0};
        checks++; if (ctl !== 11'd0) begin errors++; $display("FAIL reset_ctl: got %b expected 0", ctl); end
        checks++; if (result_out !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_out); end
        // start held through release: the first edge after release must ignore it
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_first_edge: busy %b expected 0", busy_out); end
        start_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic test_basic();
        do_op(32'h3F800000, 32'h40000000, 32'h0, 32'h0, 3'b000, 32'h40400000, 0, 0, 70);
        checks++; if (wr_first !== 2) begin errors++; $display("FAIL basic_wr_first: got %0d expected 2", wr_first); end
        checks++; if (wr_last !== 33) begin errors++; $display("FAIL basic_wr_last: got %0d expected 33", wr_last); end
        checks++; if (wr_count !== 32) begin errors++; $display("FAIL basic_wr_count: got %0d expected 32", wr_count); end
        checks++; if (done_cycle !== 67) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 67", done_cycle); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_count); end
        checks++; if (res_at_done !== 32'h40400000) begin errors++; $display("FAIL basic_result: got %h expected 40400000", res_at_done); end
        checks++; if (cap_a !== 32'h3F800000) begin errors++; $display("FAIL basic_serial4: got %h expected 3f800000", cap_a); end
        checks++; if (cap_b !== 32'h40000000) begin errors++; $display("FAIL basic_serial3: got %h expected 40000000", cap_b); end
        checks++; if (setup_seq !== 8'b0001_1110) begin errors++; $display("FAIL basic_setup: got %b expected 00011110", setup_seq); end
        checks++; if (read_count !== 32) begin errors++; $display("FAIL basic_read_count: got %0d expected 32", read_count); end
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL basic_idle_lines: got %0d expected 0", idle_bad); end
        checks++; if (busy_last !== 67) begin errors++; $display("FAIL basic_busy_last: got %0d expected 67", busy_last); end
        checks++; if (result_out !== 32'h40400000) begin errors++; $display("FAIL basic_result_hold: got %h expected 40400000", result_out); end
    endtask

    task automatic test_setup();
        do_op(32'hA5A50F0F, 32'h12345678, 32'h80000001, 32'hFFFF0000, 3'b101, 32'hC0DEF00D, 0, 0, 70);
        checks++; if (setup_seq !== 8'b1011_1110) begin errors++; $display("FAIL setup_seq: got %b expected 10111110", setup_seq); end
        checks++; if (setup_bad !== 0) begin errors++; $display("FAIL setup_early: got %0d expected 0", setup_bad); end
        checks++; if (cap_a !== 32'hA5A50F0F) begin errors++; $display("FAIL setup_serial4: got %h expected a5a50f0f", cap_a); end
        checks++; if (cap_b !== 32'h12345678) begin errors++; $display("FAIL setup_serial3: got %h expected 12345678", cap_b); end
        checks++; if (cap_c !== 32'h80000001) begin errors++; $display("FAIL setup_serial2: got %h expected 80000001", cap_c); end
        checks++; if (cap_d !== 32'hFFFF0000) begin errors++; $display("FAIL setup_serial1: got %h expected ffff0000", cap_d); end
        checks++; if (res_at_done !== 32'hC0DEF00D) begin errors++; $display("FAIL setup_result: got %h expected c0def00d", res_at_done); end
    endtask

    task automatic test_irdy_hold();
        do_op(32'h00000001, 32'h7F7FFFFF, 32'h55555555, 32'hAAAAAAAA, 3'b010, 32'h3F000000, 10, 0, 90);
        checks++; if (wr_first !== 12) begin errors++; $display("FAIL irdy_wr_first: got %0d expected 12", wr_first); end
        checks++; if (wr_count !== 32) begin errors++; $display("FAIL irdy_wr_count: got %0d expected 32", wr_count); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL irdy_single_op: got %0d expected 1", done_count); end
        checks++; if (done_cycle !== 77) begin errors++; $display("FAIL irdy_done_cycle: got %0d expected 77", done_cycle); end
        checks++; if (cap_c !== 32'h55555555) begin errors++; $display("FAIL irdy_serial2: got %h expected 55555555", cap_c); end
        checks++; if (setup_seq !== 8'b0101_1110) begin errors++; $display("FAIL irdy_setup: got %b expected 01011110", setup_seq); end
        checks++; if (res_at_done !== 32'h3F000000) begin errors++; $display("FAIL irdy_result: got %h expected 3f000000", res_at_done); end
    endtask

    task automatic test_ordy_wait();
        logic [31:0] prev;
        prev = result_out;
`ifdef FPH_TIMEOUT_EN
        do_op(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 3'b000, 32'h99999999, 0, 1000, 60);
        checks++; if (tmo_count !== 1) begin errors++; $display("FAIL tmo_count: got %0d expected 1", tmo_count); end
        checks++; if (tmo_cycle !== 50) begin errors++; $display("FAIL tmo_cycle: got %0d expected 50", tmo_cycle); end
        checks++; if (done_count !== 0) begin errors++; $display("FAIL tmo_no_done: got %0d expected 0", done_count); end
        checks++; if (read_count !== 0) begin errors++; $display("FAIL tmo_no_read: got %0d expected 0", read_count); end
        checks++; if (busy_last !== 49) begin errors++; $display("FAIL tmo_busy_last: got %0d expected 49", busy_last); end
        checks++; if (result_out !== prev) begin errors++; $display("FAIL tmo_result_kept: got %h expected %h", result_out, prev); end
`else
        do_op(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 3'b000, 32'h99999999, 0, 80, 120);
        checks++; if (tmo_count !== 0) begin errors++; $display("FAIL wait_no_timeout: got %0d expected 0", tmo_count); end
        checks++; if (done_cycle !== 114) begin errors++; $display("FAIL wait_done_cycle: got %0d expected 114", done_cycle); end
        checks++; if (busy_last !== 114) begin errors++; $display("FAIL wait_busy_last: got %0d expected 114", busy_last); end
        checks++; if (read_count !== 32) begin errors++; $display("FAIL wait_read_count: got %0d expected 32", read_count); end
        checks++; if (res_at_done !== 32'h99999999) begin errors++; $display("FAIL wait_result: got %h expected 99999999 (prev %h)", res_at_done, prev); end
`endif
    endtask

    task automatic test_reset_mid_load();
        logic [9:0] ctl;
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 32'h0, 0, 0, 16);
        checks++; if (wr_count !== 15) begin errors++; $display("FAIL midload_progress: got %0d expected 15", wr_count); end
        rst_in = 1'b0;
        #1;
        ctl = {busy_out, done_out, wr_out, output_read_out, timeout_out, serial1_out,
               serial2_out, serial3_out, serial4_out, setup_serial_out};
        checks++; if (ctl !== 10'd0) begin errors++; $display("FAIL midload_outputs: got %b expected 0", ctl); end
        checks++; if (result_out !== 32'd0) begin errors++; $display("FAIL midload_result: got %h expected 0", result_out); end
        @(posedge clk_in); #1;
        release_reset();
        do_op(32'h40490FDB, 32'hBF800000, 32'h00000000, 32'h3F800000, 3'b100, 32'h40C90FDB, 0, 0, 70);
        checks++; if (wr_first !== 2) begin errors++; $display("FAIL midload_restart_wr: got %0d expected 2", wr_first); end
        checks++; if (done_cycle !== 67) begin errors++; $display("FAIL midload_restart_done: got %0d expected 67", done_cycle); end
        checks++; if (cap_a !== 32'h40490FDB) begin errors++; $display("FAIL midload_restart_serial4: got %h expected 40490fdb", cap_a); end
        checks++; if (setup_seq !== 8'b1001_1110) begin errors++; $display("FAIL midload_restart_setup: got %b expected 10011110", setup_seq); end
        checks++; if (res_at_done !== 32'h40C90FDB) begin errors++; $display("FAIL midload_restart_result: got %h expected 40c90fdb", res_at_done); end
    endtask

    task automatic test_back_to_back();
        do_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b001, 32'h40800000, 0, 0, 67);
        checks++; if (done_cycle !== 67) begin errors++; $display("FAIL b2b_first_done: got %0d expected 67", done_cycle); end
        @(posedge clk_in); #1;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy %b expected 0", busy_out); end
        do_op(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00FF00FF, 32'hFF00FF00, 3'b110, 32'h12345678, 0, 0, 70);
        checks++; if (wr_first !== 2) begin errors++; $display("FAIL b2b_second_wr: got %0d expected 2", wr_first); end
        checks++; if (cap_d !== 32'hFF00FF00) begin errors++; $display("FAIL b2b_serial1: got %h expected ff00ff00", cap_d); end
        checks++; if (res_at_done !== 32'h12345678) begin errors++; $display("FAIL b2b_result: got %h expected 12345678", res_at_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_setup();
        test_irdy_hold();
        test_ordy_wait();
        test_reset_mid_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_adder_host.md
FP_ADDER_HOST -- requirements
Module: fp_adder_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum WAIT_ORDY cycles before abort (used only with FPH_TIMEOUT_EN).
REQ-002 SHALL have ports, one clock, reset asynchronous and active-low:
  clk_in  in  1  sole clock
  rst_in  in  1  asynchronous active-low reset
  start_in  in  1  request one operation
  op_a_in, op_b_in, op_c_in, op_d_in  in  32 each  FP32 operands
  sub_op_in  in  3  subtract-select per operand stage
  busy_out  out  1  operation in progress
  done_out  out  1  one-cycle completion pulse
  result_out  out  32  last FP32 result
  timeout_out  out  1  one-cycle abort pulse
  serial1_out..serial4_out  out  1 each  operand bit streams to adder
  setup_serial_out  out  1  setup byte bit stream
  wr_out  out  1  load strobe to adder
  dev_input_rdy_in  in  1  adder ready to accept operands
  dev_output_rdy_in  in  1  adder result available
  output_read_out  out  1  result read strobe
  dev_serial_in  in  1  adder result bit stream

Function
REQ-003 SHALL implement FSM states IDLE, WAIT_IRDY, LOAD, WAIT_ORDY, READ, DONE.
REQ-004 IDLE: start_in=1 SHALL latch operands and sub_op_in, go WAIT_IRDY; busy_out=1 in all states except IDLE.
REQ-005 start_in outside IDLE SHALL be ignored (no queueing).
REQ-006 WAIT_IRDY SHALL go LOAD the cycle after dev_input_rdy_in is sampled 1.
REQ-007 LOAD SHALL last exactly 32 cycles with wr_out=1, driving bit 31 first, bit 0 last: serial4_out=op_a, serial3_out=op_b, serial2_out=op_c, serial1_out=op_d.
REQ-008 Setup byte SHALL be {sub_op[2:0], 4'b1111, 1'b0} (bit 0 = internal output clock), driven MSB-first on setup_serial_out during LOAD cycles 25..32; 0 in cycles 1..24.
REQ-009 Outside LOAD, wr_out, serial*_out, setup_serial_out SHALL be 0.
REQ-010 WAIT_ORDY SHALL go READ the cycle after dev_output_rdy_in is sampled 1.
REQ-011 READ SHALL last exactly 32 cycles with output_read_out=1, sampling dev_serial_in each cycle into a shift register MSB-first.
REQ-012 DONE SHALL last one cycle: result_out updated with assembled word, done_out=1, then IDLE.
REQ-013 result_out SHALL hold its value until next DONE; unchanged by aborts.
REQ-014 Minimum start-to-done latency with both ready inputs constantly 1: 1 (WAIT_IRDY) + 32 (LOAD) + 1 (WAIT_ORDY) + 32 (READ) + 1 (DONE) = done_out in cycle 67 after the start cycle.
REQ-015 Bit counter SHALL be 5 bits, count 31 down to 0, exit phase on 0; no wrap into a second word.

Reset
REQ-016 rst_in=0 SHALL asynchronously force IDLE, counters 0, all outputs 0 including result_out, at any point incl. mid-LOAD/READ.
REQ-017 Release SHALL be synchronized; first start_in honoured on second clk_in edge after release.

Configuration
REQ-018 With FPH_TIMEOUT_EN defined: WAIT_ORDY counter; reaching TIMEOUT_CYCLES SHALL pulse timeout_out one cycle, return IDLE, no done_out.
REQ-019 Without FPH_TIMEOUT_EN: WAIT_ORDY waits indefinitely; timeout_out tied 0; no counter logic.

Structure
REQ-020 Shared package fp_adder_pkg SHALL hold FSM state enum, WORD_W=32, SETUP_W=8, SETUP_EN_ALL=4'b1111, SETUP_CLK_INT=1'b0.
REQ-021 One sub-module fph_piso32 (32-bit load/shift register) SHALL be instantiated for each of the four operand streams.

Verification
REQ-022 a=0x3F800000, b=0x40000000, c=d=0, sub_op=000, stub returns 0x40400000 -> wr_out high cycles 2..33, done_out cycle 67, result_out=0x40400000.
REQ-023 sub_op=101 -> setup_serial_out sequence 1,0,1,1,1,1,1,0 in LOAD cycles 25..32; serial lines match operand MSB-first.
REQ-024 dev_input_rdy_in held 0 for 10 cycles, start_in re-pulsed meanwhile -> LOAD starts cycle after rdy rises; single operation only.
REQ-025 rst_in=0 at LOAD cycle 15 -> all outputs 0 immediately; next start completes a full normal transfer.
REQ-026 FPH_TIMEOUT_EN, TIMEOUT_CYCLES=16, dev_output_rdy_in stuck 0 -> timeout_out pulse, IDLE, result_out unchanged, no done_out.
